// File: rtl/pixel_readout_slave.sv
// pixel_readout_slave: phase decoder, ramp-capture pixel memory and row readout
// for a 2x2 pixel array, with sticky protocol-error flag and frame counter.
module pixel_readout_slave #(
   parameter int DATA_W  = 8,
   parameter int FRAME_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               erase,
   input  logic               expose,
   input  logic               convert,
   input  logic               read1,
   input  logic               read2,
   input  logic [3:0]         cmp,
   input  logic [DATA_W-1:0]  data_in,
   output logic [DATA_W-1:0]  col1_out,
   output logic [DATA_W-1:0]  col2_out,
   output logic               col_oe,
   output logic [3:0]         tripped,
   output logic               busy,
   output logic               seq_err,
   output logic [FRAME_W-1:0] frame_cnt
);
   typedef enum logic [2:0] {IDLE, ERASED, EXPOSING, CONVERTING, CONVERTED, READ1, READ2} state_t;
   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_mem [4];
   logic              r_from_exp, r_row1;
   logic              w_multi, w_err, w_sample, w_frame, w_erase;
   always_comb begin
      w_next   = r_state;
      w_err    = 1'b0;
      w_multi  = $countones({erase, expose, convert, read1, read2}) > 1;
      if (w_multi)
         w_err = 1'b1;
      else if (erase)
         w_next = ERASED;
      else if (convert) begin
         if (r_state == EXPOSING || r_state == CONVERTING || (r_state == IDLE && r_from_exp))
            w_next = CONVERTING;
         else
            w_err = 1'b1;
      end else if (read1 || read2) begin
         if (r_state == CONVERTED || r_state == READ1 || r_state == READ2)
            w_next = read1 ? READ1 : READ2;
         else
            w_err = 1'b1;
      end else if (expose) begin
         if (r_state == ERASED)
            w_next = EXPOSING;
      end else if (r_state == EXPOSING)
         w_next = IDLE;
      else if (r_state == CONVERTING || r_state == READ1 || r_state == READ2)
         w_next = CONVERTED;
      w_erase  = erase && !w_multi;
      w_sample = convert && !w_multi && w_next == CONVERTING;
      w_frame  = r_state == READ2 && w_next != READ2 && r_row1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_from_exp <= 1'b0;
         r_row1     <= 1'b0;
         col1_out   <= '0;
         col2_out   <= '0;
         col_oe     <= 1'b0;
         tripped    <= '0;
         busy       <= 1'b0;
         seq_err    <= 1'b0;
         frame_cnt  <= '0;
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      end else begin
         r_state  <= w_next;
         busy     <= w_next == EXPOSING || w_next == CONVERTING;
         col_oe   <= w_next == READ1 || w_next == READ2;
         col1_out <= w_next == READ1 ? r_mem[0] : w_next == READ2 ? r_mem[2] : '0;
         col2_out <= w_next == READ1 ? r_mem[1] : w_next == READ2 ? r_mem[3] : '0;
         if (w_err) seq_err <= 1'b1;
         if (w_frame) frame_cnt <= frame_cnt + 1'b1;
         // IDLE only remembers an exposure if it was entered straight from EXPOSING
         if (r_state == EXPOSING && w_next == IDLE) r_from_exp <= 1'b1;
         else if (w_next != IDLE) r_from_exp <= 1'b0;
         if (w_next == READ1 && r_state != READ1) r_row1 <= 1'b1;
         else if (w_frame) r_row1 <= 1'b0;
         for (int i = 0; i < 4; i++)
            if (w_sample && !tripped[i]) begin
               if (cmp[i]) r_mem[i] <= data_in;
               else tripped[i] <= 1'b1;
            end
         if (w_erase) begin
            tripped <= '0;
            seq_err <= 1'b0;
            r_row1  <= 1'b0;
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
         end
      end
   end
endmodule

// File: doc/pixel_readout_slave.md
# pixel_readout_slave

Synthesizable sensor-side digital back end for the 2x2 pixel array. It decodes the controller's erase/expose/convert/read1/read2 phase strobes and captures the shared ADC ramp count into a per-pixel memory when each pixel comparator trips. It drives the stored values back to the controller one row at a time and flags illegal phase sequences. It sits between the analog pixel comparators and the controller/ADC model, and is the responder to the controller's readout protocol.

## Interface
- DATA_W, 8, width of ramp count and of each pixel memory word
- FRAME_W, 16, width of completed-frame counter
- clk  in  1  clock; all inputs sampled on posedge (controller changes them on negedge)
- reset  in  1  asynchronous, active-high
- erase  in  1  erase phase strobe
- expose  in  1  expose phase strobe
- convert  in  1  convert phase strobe; data_in ramps while high
- read1  in  1  row-1 readout strobe (pixels 11, 12)
- read2  in  1  row-2 readout strobe (pixels 21, 22)
- cmp  in  4  comparator outputs, bit order {22,21,12,11}; 1 = pixel voltage still above ramp
- data_in  in  DATA_W  shared ADC ramp count
- col1_out  out  DATA_W  column-1 data (pixel x1 of selected row)
- col2_out  out  DATA_W  column-2 data (pixel x2 of selected row)
- col_oe  out  1  column outputs valid / bus driven
- tripped  out  4  sticky per-pixel trip flags, same bit order as cmp
- busy  out  1  high in EXPOSING or CONVERTING
- seq_err  out  1  sticky protocol-error flag
- frame_cnt  out  FRAME_W  count of completed frames

## Operation
- States: IDLE, ERASED, EXPOSING, CONVERTING, CONVERTED, READ1, READ2.
- A cycle is "multi" if more than one strobe is high. It sets seq_err; all strobes are ignored that cycle and the state holds.
- erase=1 from any state: go to ERASED, clear all mem words to 0, clear tripped, clear seq_err. erase is the only way to clear seq_err.
- ERASED + expose goes to EXPOSING. EXPOSING with expose=0 and no strobe goes to IDLE.
- CONVERTING is entered on convert from EXPOSING, or from IDLE if the previous phase was EXPOSING. convert from any other state sets seq_err and changes no state and no mem.
- In CONVERTING, each posedge, per pixel i:
  - if cmp[i]=1 and tripped[i]=0: mem[i] <= data_in.
  - if cmp[i]=0 and tripped[i]=0: tripped[i] <= 1 and mem[i] holds.
  - Net effect: mem holds the data_in value of the last cycle before the trip.
- A pixel that never trips holds the final ramp value when convert falls. tripped stays 0.
- convert falling (no strobe) goes to CONVERTED.
- read1 in CONVERTED or READ2 goes to READ1. read2 in CONVERTED or READ1 goes to READ2.
- Any read outside CONVERTED/READ1/READ2 sets seq_err; outputs stay 0 and col_oe stays 0.
- Dropping a read strobe returns to CONVERTED, so rows may be re-read.
- frame_cnt increments by 1, wrapping at 2^FRAME_W, on the cycle READ2 exits after row 1 has been read since the last erase.
- mem is only written in CONVERTING or on erase.

## Timing
- Reset values: all mem 0, col1_out=0, col2_out=0, col_oe=0, tripped=0, busy=0, seq_err=0, frame_cnt=0, state IDLE.
- Reset asserted mid-convert or mid-read aborts immediately. Outputs take reset values asynchronously.
- col_out and col_oe are registered, with 1-cycle latency. At the posedge that samples read1=1, col_oe goes 1 and col1_out/col2_out = mem11/mem12 from that edge.
- The first posedge that samples read1=0 drives col_oe=0 and both col_out=0.
- A direct read1-to-read2 switch changes the data in one cycle; col_oe stays 1.
- tripped updates on the same posedge as the comparator sample. busy is a registered decode of the state.
- seq_err rises on the posedge that samples the violation.

## Test plan
- Normal frame, with cmp bits falling when data_in reaches 40, 100, 7, 200 (pixels 11, 12, 21, 22), and data_in ramping 1..255:
  - read1 → col1_out=39, col2_out=100-1=99, col_oe=1 one cycle after read1.
  - read2 → 6 and 199.
  - frame_cnt=1 after read2 drops.
- Pixel 22 never trips (cmp[3]=1 throughout convert, ramp ending at 255) → mem22=255, tripped=4'b0111, read2 col2_out=255.
- convert asserted straight after reset without expose → seq_err=1, tripped=0, and a later read1 gives col_oe=0. A subsequent erase clears seq_err.
- read1 and read2 high together in CONVERTED → seq_err=1, state stays CONVERTED, col_oe=0.
- Reset asserted mid-convert at data_in=120 → all outputs 0 immediately. Then erase/expose/convert with trips at 50 → reads return 49, and frame_cnt restarts from 0 to 1.
- frame_cnt wrap: with FRAME_W=2, run 4 complete frames → frame_cnt=0. Re-reading row 2 twice in one frame increments only once.
